i3c_pad_ctrl: RTL and testbench
===============================

# i3c_pad_ctrl

Parametrised multi-lane I3C pad controller sitting between the I3C protocol engine and a row of BBI3C-class bidirectional pad buffers. Per lane: open-drain / push-pull drive selection, a timed push-pull-high handover window with strong pull-up, resistor-enable sequencing, input synchronisation with optional glitch filtering, and arbitration-loss detection. One instance serves all SDA/SCL lanes of a controller.

## Interface
Parameters:
- LANES, 2, number of independent pad lanes
- HOLD_CYC, 2, handover cycles driving high after leaving push-pull high; 0 disables handover
- FILT_CYC, 3, consecutive stable samples required by the glitch filter (1..15)
- CNT_W, 4, width of the hold and filter counters; must hold max(HOLD_CYC, FILT_CYC)

Ports:
- CLK  in  1  sole clock; all state is in this domain
- RST  in  1  asynchronous, active-high reset
- MODE_REQ  in  2*LANES  per-lane request: 00 RELEASE, 01 OD, 10 PP, 11 treated as RELEASE
- DATA  in  LANES  per-lane drive value
- PULL_REQ  in  LANES  per-lane request for the pad pull-up resistor
- PAD_O  in  LANES  raw receive value from the pad buffer
- PAD_I  out  LANES  drive value to the pad buffer
- PAD_T  out  LANES  tristate to the pad buffer; 1 = released
- PAD_RESEN  out  LANES  pad resistor enable
- PAD_PULLUPEN  out  LANES  pad strong pull-up enable
- RX  out  LANES  synchronised (and filtered) receive value
- BUSY  out  LANES  lane in handover window
- ARB_LOST  out  LANES  one-cycle pulse on arbitration loss

## Operation
- Per-lane FSM states: REL, OD, PP, HAND. Reset state REL.
- MODE_REQ, DATA, PULL_REQ are registered each cycle; the FSM acts on registered values.
- REL: PAD_T=1, PAD_I=0. OD: PAD_I=0, PAD_T=DATA (drive low for 0, release for 1). PP: PAD_T=0, PAD_I=DATA. HAND: PAD_T=0, PAD_I=1.
- Leaving PP while the last driven value was 1 and HOLD_CYC>0: enter HAND, load counter with HOLD_CYC, latch target state. Leaving PP with last value 0, or HOLD_CYC=0: go directly to target.
- In HAND: counter decrements each cycle; at 1 go to latched target. A new request during HAND updates the latched target without restarting the counter; a request for PP during HAND goes to PP immediately.
- PAD_RESEN = registered PULL_REQ while state is REL or OD; 0 in PP and HAND.
- PAD_PULLUPEN = 1 only in HAND.
- BUSY = 1 exactly while in HAND.
- Receive path: 2-flop synchroniser on PAD_O, then filter: RX takes the synchronised value only after FILT_CYC consecutive equal samples; any mismatch reloads the counter.
- ARB_LOST: single-cycle pulse on an RX 1->0 transition while the lane is in OD with registered DATA=1, or in PP with registered DATA=1.

## Timing
- Reset values: PAD_T=1, PAD_I=0, PAD_RESEN=0, PAD_PULLUPEN=0, RX=1, BUSY=0, ARB_LOST=0; synchroniser and filter flops preset to 1.
- Request to pad output: 2 cycles (input register + state register; outputs decoded registered).
- PAD_O to RX: 2 cycles synchroniser + FILT_CYC cycles filter (unfiltered build: 2 cycles).
- HAND duration exactly HOLD_CYC cycles.
- RST mid-handover: lane returns to REL at once; no residual drive.
- Lanes fully independent; simultaneous requests on all lanes allowed.

## Configuration
- I3C_PAD_GLITCH_FILT_EN defined: filter instantiated per lane as above.
- Undefined: filter omitted; RX is the synchroniser output directly; FILT_CYC ignored.

## Structure
- Package i3c_pad_pkg: lane state enum (REL, OD, PP, HAND), MODE_REQ encodings, reset constants for RX.
- Sub-module i3c_pad_filt: one lane's synchroniser + glitch filter, instantiated LANES times via generate.

## Test plan
- Reset asserted mid-HAND, LANES=2 -> all PAD_T=1, PAD_PULLUPEN=0, RX=1 immediately.
- Lane 0 PP with DATA=1, then MODE_REQ=OD -> PAD_I=1, PAD_T=0, BUSY=1, PAD_PULLUPEN=1 for exactly 2 cycles, then PAD_T=1.
- Lane 0 PP DATA=0 then REL -> no HAND, PAD_T=1 one cycle after state change, BUSY stays 0.
- OD, DATA=1, PAD_O forced 0 steady -> RX falls after 2+3 cycles, ARB_LOST pulses once.
- PAD_O 2-cycle low glitch with filter enabled -> RX stays 1; without macro -> RX follows glitch.
- PULL_REQ=1 across REL->PP->REL -> PAD_RESEN 1, 0 during PP and HAND, 1 again after.

Source files
------------

// File: rtl/i3c_pad_pkg.sv
// Shared lane-state encodings, mode request codes and receive-path reset value for i3c_pad_ctrl.
package i3c_pad_pkg;

  localparam logic [1:0] ST_REL  = 2'd0;
  localparam logic [1:0] ST_OD   = 2'd1;
  localparam logic [1:0] ST_PP   = 2'd2;
  localparam logic [1:0] ST_HAND = 2'd3;

  localparam logic [1:0] MODE_REL = 2'b00;
  localparam logic [1:0] MODE_OD  = 2'b01;
  localparam logic [1:0] MODE_PP  = 2'b10;

  // Idle I3C bus lines float high, so the receive path powers up reading 1.
  localparam logic RX_RST = 1'b1;

  function automatic logic [1:0] mode_target(input logic [1:0] mode);
    case (mode)
      MODE_OD: return ST_OD;
      MODE_PP: return ST_PP;
      default: return ST_REL;
    endcase
  endfunction

endpackage

// File: rtl/i3c_pad_filt.sv
// One lane's 2-flop PAD_O synchroniser plus optional glitch filter (I3C_PAD_GLITCH_FILT_EN).
// Filtered: RX adopts a new level after FILT_CYC consecutive samples of it; otherwise RX is the synchroniser output.
module i3c_pad_filt
  import i3c_pad_pkg::*;
#(
  parameter int FILT_CYC = 3,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_o,
  output logic rx
);

  logic sync1;
  logic sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= RX_RST;
      sync2 <= RX_RST;
    end else begin
      sync1 <= pad_o;
      sync2 <= sync1;
    end
  end

`ifdef I3C_PAD_GLITCH_FILT_EN
  logic [CNT_W-1:0] cnt;
  logic             rx_q;

  // cnt counts samples that disagree with rx; any agreeing sample restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q <= RX_RST;
      cnt  <= '0;
    end else if (sync2 == rx_q) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(FILT_CYC - 1)) begin
      rx_q <= sync2;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign rx = rx_q;
`else
  assign rx = sync2;
`endif

endmodule

// File: rtl/i3c_pad_ctrl.sv
// Multi-lane I3C pad controller: OD/PP drive selection, push-pull-high handover, pull-up sequencing, arbitration-loss detect.
// Per-lane glitch filter on the receive path is built only when I3C_PAD_GLITCH_FILT_EN is defined.
module i3c_pad_ctrl
  import i3c_pad_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int HOLD_CYC = 2,
  parameter int FILT_CYC = 3,
  parameter int CNT_W    = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [2*LANES-1:0] MODE_REQ,
  input  logic [LANES-1:0]   DATA,
  input  logic [LANES-1:0]   PULL_REQ,
  input  logic [LANES-1:0]   PAD_O,
  output logic [LANES-1:0]   PAD_I,
  output logic [LANES-1:0]   PAD_T,
  output logic [LANES-1:0]   PAD_RESEN,
  output logic [LANES-1:0]   PAD_PULLUPEN,
  output logic [LANES-1:0]   RX,
  output logic [LANES-1:0]   BUSY,
  output logic [LANES-1:0]   ARB_LOST
);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [1:0]       mode_r;
    logic             data_r;
    logic             pull_r;
    logic [1:0]       state;
    logic [1:0]       tgt;
    logic [CNT_W-1:0] hold_cnt;
    logic             rx;
    logic             rx_d;
    logic             pad_i;
    logic             pad_t;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        mode_r <= MODE_REL;
        data_r <= 1'b0;
        pull_r <= 1'b0;
      end else begin
        mode_r <= MODE_REQ[2*g +: 2];
        data_r <= DATA[g];
        pull_r <= PULL_REQ[g];
      end
    end

    // mode_r is held until the requester changes it, so it doubles as the latched handover target.
    assign tgt = mode_target(mode_r);

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        state    <= ST_REL;
        hold_cnt <= '0;
      end else begin
        case (state)
          ST_PP: begin
            if (tgt != ST_PP) begin
              if (data_r && (HOLD_CYC > 0)) begin
                state    <= ST_HAND;
                hold_cnt <= CNT_W'(HOLD_CYC);
              end else begin
                state <= tgt;
              end
            end
          end
          ST_HAND: begin
            if (tgt == ST_PP || hold_cnt == CNT_W'(1)) begin
              state <= tgt;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
          default: state <= tgt;
        endcase
      end
    end

    always_comb begin
      pad_i = 1'b0;
      pad_t = 1'b1;
      case (state)
        ST_OD:   pad_t = data_r;
        ST_PP:   begin pad_t = 1'b0; pad_i = data_r; end
        ST_HAND: begin pad_t = 1'b0; pad_i = 1'b1;   end
        default: ;
      endcase
    end

    i3c_pad_filt #(
      .FILT_CYC (FILT_CYC),
      .CNT_W    (CNT_W)
    ) u_filt (
      .clk   (CLK),
      .rst   (RST),
      .pad_o (PAD_O[g]),
      .rx    (rx)
    );

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) rx_d <= RX_RST;
      else     rx_d <= rx;
    end

    assign PAD_I[g]        = pad_i;
    assign PAD_T[g]        = pad_t;
    assign PAD_RESEN[g]    = pull_r & (state == ST_REL || state == ST_OD);
    assign PAD_PULLUPEN[g] = (state == ST_HAND);
    assign BUSY[g]         = (state == ST_HAND);
    assign RX[g]           = rx;
    // We lost arbitration if the line falls while we are letting it (or driving it) high.
    assign ARB_LOST[g]     = rx_d & ~rx & data_r & (state == ST_OD || state == ST_PP);
  end

endmodule

// File: tb/tb_i3c_pad_ctrl.sv
// Directed bench for i3c_pad_ctrl (LANES=2, HOLD_CYC=2, FILT_CYC=3); expectations follow I3C_PAD_GLITCH_FILT_EN.
module tb_i3c_pad_ctrl;

`ifdef I3C_PAD_GLITCH_FILT_EN
  localparam int RX_LAT  = 5;
  localparam bit FILT_ON = 1'b1;
`else
  localparam int RX_LAT  = 2;
  localparam bit FILT_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] MODE_REQ;
  logic [1:0] DATA;
  logic [1:0] PULL_REQ;
  logic [1:0] PAD_O;
  logic [1:0] PAD_I;
  logic [1:0] PAD_T;
  logic [1:0] PAD_RESEN;
  logic [1:0] PAD_PULLUPEN;
  logic [1:0] RX;
  logic [1:0] BUSY;
  logic [1:0] ARB_LOST;

  int pass_cnt  = 0;
  int total_cnt = 0;

  i3c_pad_ctrl #(
    .LANES    (2),
    .HOLD_CYC (2),
    .FILT_CYC (3),
    .CNT_W    (4)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .MODE_REQ     (MODE_REQ),
    .DATA         (DATA),
    .PULL_REQ     (PULL_REQ),
    .PAD_O        (PAD_O),
    .PAD_I        (PAD_I),
    .PAD_T        (PAD_T),
    .PAD_RESEN    (PAD_RESEN),
    .PAD_PULLUPEN (PAD_PULLUPEN),
    .RX           (RX),
    .BUSY         (BUSY),
    .ARB_LOST     (ARB_LOST)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset;
    RST      = 1'b1;
    MODE_REQ = 4'b0000;
    DATA     = 2'b00;
    PULL_REQ = 2'b00;
    PAD_O    = 2'b11;
    step(2);
    total_cnt++;
    if ({PAD_T, PAD_I, PAD_RESEN, PAD_PULLUPEN} !== 8'b11_00_00_00)
      $display("FAIL reset_drive got T=%b I=%b RESEN=%b PU=%b exp T=11 I=00 RESEN=00 PU=00",
               PAD_T, PAD_I, PAD_RESEN, PAD_PULLUPEN);
    else pass_cnt++;
    total_cnt++;
    if ({RX, BUSY, ARB_LOST} !== 6'b11_00_00)
      $display("FAIL reset_status got RX=%b BUSY=%b ARB=%b exp RX=11 BUSY=00 ARB=00", RX, BUSY, ARB_LOST);
    else pass_cnt++;
    RST = 1'b0;
    step(1);
  endtask

  task automatic test_handover;
    MODE_REQ[1:0] = 2'b10;
    DATA[0]       = 1'b1;
    step(3);
    total_cnt++;
    if ({PAD_T[0], PAD_I[0]} !== 2'b01)
      $display("FAIL pp_high got T=%b I=%b exp T=0 I=1", PAD_T[0], PAD_I[0]);
    else pass_cnt++;
    MODE_REQ[1:0] = 2'b01;
    step(1);
    total_cnt++;
    if (BUSY[0] !== 1'b0) $display("FAIL hand_early got BUSY=%b exp 0", BUSY[0]);
    else pass_cnt++;
    for (int c = 0; c < 2; c++) begin
      step(1);
      total_cnt++;
      if ({PAD_I[0], PAD_T[0], BUSY[0], PAD_PULLUPEN[0]} !== 4'b1011)
        $display("FAIL hand_cyc%0d got I=%b T=%b BUSY=%b PU=%b exp I=1 T=0 BUSY=1 PU=1",
                 c, PAD_I[0], PAD_T[0], BUSY[0], PAD_PULLUPEN[0]);
      else pass_cnt++;
    end
    step(1);
    total_cnt++;
    if ({PAD_T[0], BUSY[0], PAD_PULLUPEN[0], PAD_T[1]} !== 4'b1001)
      $display("FAIL hand_exit got T0=%b BUSY=%b PU=%b T1=%b exp T0=1 BUSY=0 PU=0 T1=1",
               PAD_T[0], BUSY[0], PAD_PULLUPEN[0], PAD_T[1]);
    else pass_cnt++;
  endtask

  task automatic test_arb;
    int arb_n = 0;
    PAD_O[0] = 1'b0;
    for (int k = 1; k <= RX_LAT + 2; k++) begin
      step(1);
      arb_n += int'(ARB_LOST[0]);
      if (k == RX_LAT - 1) begin
        total_cnt++;
        if (RX[0] !== 1'b1) $display("FAIL arb_rx_early got RX=%b exp 1", RX[0]);
        else pass_cnt++;
      end
      if (k == RX_LAT) begin
        total_cnt++;
        if ({RX[0], ARB_LOST[0]} !== 2'b01)
          $display("FAIL arb_fall got RX=%b ARB=%b exp RX=0 ARB=1", RX[0], ARB_LOST[0]);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (arb_n !== 1) $display("FAIL arb_pulses got %0d exp 1", arb_n);
    else pass_cnt++;
    PAD_O[0] = 1'b1;
    step(RX_LAT + 1);
    total_cnt++;
    if ({RX[0], ARB_LOST[0]} !== 2'b10)
      $display("FAIL arb_recover got RX=%b ARB=%b exp RX=1 ARB=0", RX[0], ARB_LOST[0]);
    else pass_cnt++;
  endtask

  task automatic test_pp_low;
    MODE_REQ[1:0] = 2'b10;
    DATA[0]       = 1'b0;
    step(3);
    total_cnt++;
    if ({PAD_T[0], PAD_I[0]} !== 2'b00)
      $display("FAIL pp_low got T=%b I=%b exp T=0 I=0", PAD_T[0], PAD_I[0]);
    else pass_cnt++;
    MODE_REQ[1:0] = 2'b00;
    step(1);
    total_cnt++;
    if ({PAD_T[0], BUSY[0]} !== 2'b00)
      $display("FAIL pp_low_hold got T=%b BUSY=%b exp T=0 BUSY=0", PAD_T[0], BUSY[0]);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if ({PAD_T[0], BUSY[0], PAD_PULLUPEN[0]} !== 3'b100)
      $display("FAIL pp_low_rel got T=%b BUSY=%b PU=%b exp T=1 BUSY=0 PU=0", PAD_T[0], BUSY[0], PAD_PULLUPEN[0]);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (BUSY[0] !== 1'b0) $display("FAIL pp_low_busy got BUSY=%b exp 0", BUSY[0]);
    else pass_cnt++;
  endtask

  task automatic test_glitch;
    PAD_O[1] = 1'b0;
    step(2);
    PAD_O[1] = 1'b1;
    total_cnt++;
    if (RX[1] !== FILT_ON) $display("FAIL glitch_k2 got RX=%b exp %b", RX[1], FILT_ON);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (RX[1] !== FILT_ON) $display("FAIL glitch_k3 got RX=%b exp %b", RX[1], FILT_ON);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (RX[1] !== 1'b1) $display("FAIL glitch_k4 got RX=%b exp 1", RX[1]);
    else pass_cnt++;
    step(4);
    total_cnt++;
    if ({RX[1], ARB_LOST[1]} !== 2'b10)
      $display("FAIL glitch_settle got RX=%b ARB=%b exp RX=1 ARB=0", RX[1], ARB_LOST[1]);
    else pass_cnt++;
  endtask

  task automatic test_pull;
    logic [1:0] exp_resen [7];
    logic [1:0] exp_busy  [7];
    exp_resen = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    exp_busy  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00};
    PULL_REQ[1] = 1'b1;
    step(2);
    total_cnt++;
    if (PAD_RESEN !== exp_resen[0]) $display("FAIL pull_rel got RESEN=%b exp %b", PAD_RESEN, exp_resen[0]);
    else pass_cnt++;
    MODE_REQ[3:2] = 2'b10;
    DATA[1]       = 1'b1;
    for (int k = 1; k < 7; k++) begin
      if (k == 3) MODE_REQ[3:2] = 2'b00;
      step(1);
      total_cnt++;
      if ({PAD_RESEN, BUSY} !== {exp_resen[k], exp_busy[k]})
        $display("FAIL pull_seq%0d got RESEN=%b BUSY=%b exp RESEN=%b BUSY=%b",
                 k, PAD_RESEN, BUSY, exp_resen[k], exp_busy[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_hand;
    MODE_REQ = 4'b1010;
    DATA     = 2'b11;
    PAD_O    = 2'b00;
    step(RX_LAT + 2);
    total_cnt++;
    if (RX !== 2'b00) $display("FAIL midrst_pre_rx got RX=%b exp 00", RX);
    else pass_cnt++;
    MODE_REQ = 4'b0000;
    step(2);
    total_cnt++;
    if ({BUSY, PAD_PULLUPEN} !== 4'b1111)
      $display("FAIL midrst_in_hand got BUSY=%b PU=%b exp BUSY=11 PU=11", BUSY, PAD_PULLUPEN);
    else pass_cnt++;
    RST = 1'b1;
    #1;
    total_cnt++;
    if ({PAD_T, PAD_I, PAD_PULLUPEN, RX, BUSY} !== 10'b11_00_00_11_00)
      $display("FAIL midrst_async got T=%b I=%b PU=%b RX=%b BUSY=%b exp T=11 I=00 PU=00 RX=11 BUSY=00",
               PAD_T, PAD_I, PAD_PULLUPEN, RX, BUSY);
    else pass_cnt++;
    PAD_O = 2'b11;
    step(2);
    RST = 1'b0;
    step(1);
  endtask

  initial begin
    test_reset();
    test_handover();
    test_arb();
    test_pp_low();
    test_glitch();
    test_pull();
    test_reset_mid_hand();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
